grid_cursor: RTL and testbench
==============================

# grid_cursor

Parametrised whiteboard cursor controller with per-axis auto-repeat, edge wrap and a pen write port. It takes four active-low direction buttons, advances a cursor over a GRID_W x GRID_H cell grid and issues one-cycle framebuffer write requests. It sits between the board buttons/switches and the framebuffer write side, and drives the cursor overlay in the VGA path.

## Interface
Parameters:
- GRID_W, 80, grid columns (>=2)
- GRID_H, 60, grid rows (>=2)
- INIT_DELAY, 5_000_000, clocks from first step to first repeat step (>=1)
- REPEAT_DELAY, 1_250_000, clocks between repeat steps (>=1)
- X_W / Y_W, $clog2(GRID_W) / $clog2(GRID_H), coordinate widths (derived, not overridden)

Ports:
- clk  in  1  single clock (25 MHz pixel clock)
- rst_n  in  1  asynchronous, active-low reset
- btn_up_n, btn_down_n, btn_left_n, btn_right_n  in  1 each  active-low buttons, asynchronous to clk
- run  in  1  1 = motion and writes enabled, 0 = paused
- pen_mode  in  2  00 hover, 01 draw (color 1), 10 erase (color 0), 11 hover
- wrap_en  in  1  1 = wrap at grid edges, 0 = saturate
- clear  in  1  synchronous home command
- cur_x / cur_y  out  X_W / Y_W  cursor position
- wr_en  out  1  one-cycle write strobe
- wr_x / wr_y  out  X_W / Y_W  write address
- wr_color  out  1  pixel value to write

## Operation
- Each button passes through a 2-flop synchroniser. Pressed = synchronised level 0.
- Per axis, the net direction is: 0 when neither or both opposing buttons are pressed, else +1 or -1. Both pressed counts as released.
- Per-axis repeat FSM:
  - IDLE: on nonzero direction, issue step, load timer with INIT_DELAY-1, go to HOLD.
  - HOLD: decrement timer. At 0, issue step, load REPEAT_DELAY-1, go to REPEAT.
  - REPEAT: decrement timer. At 0, issue step and reload REPEAT_DELAY-1.
  - Direction 0 in any state returns the FSM to IDLE with no step.
  - A direction reversal (+1 to -1) is treated as release then press: IDLE for one cycle, then a new first step.
- Step arithmetic:
  - +1 at GRID_W-1 (GRID_H-1) gives GRID_W-1 when wrap_en=0, 0 when wrap_en=1.
  - -1 at 0 gives 0 when wrap_en=0, GRID_W-1 when wrap_en=1.
  - The X and Y axes may step in the same cycle (diagonal move).
- Write rules:
  - pen_mode 01/10: a write is requested in the cycle after any step, including a saturated step.
  - A transition of pen_mode from hover to draw/erase while run=1 also requests one write of the current cell.
  - Hover never writes.
- run=0: both FSMs are forced to IDLE, no steps, no writes. Position holds.
- clear: highest priority after reset. Sets cur_x=cur_y=0, forces both FSMs to IDLE and sets wr_en=0 that cycle. No write is issued for the home cell.
- Reset values: cur_x, cur_y, wr_x, wr_y, wr_color = 0; wr_en = 0; FSMs in IDLE; timers = 0; synchroniser flops = 1 (released).

## Timing
- Pin falls before edge k: synchronised press is visible after edge k+1, and cur_x/cur_y update at edge k+2.
- wr_en is high for exactly one cycle after edge k+3, with wr_x/wr_y equal to the updated position and wr_color = pen_mode[0].
- Holding a button gives steps at cycles t, t+INIT_DELAY, then t+INIT_DELAY+n*REPEAT_DELAY.
- At most one write per cycle. Writes are registered (no combinational path from inputs to outputs).
- Reset asserted mid-hold: everything returns to reset values immediately. On release, a still-held button counts as a new press: first step 2 edges after synchronisation.

## Structure
- Package grid_cursor_pkg holds the pen_mode encodings (PEN_HOVER, PEN_DRAW, PEN_ERASE), the repeat FSM state enum and the direction type.
- Sub-module axis_repeat is instantiated twice (X, Y). Its parameters are LIMIT, INIT_DELAY and REPEAT_DELAY. Inputs are pos_dec_n and pos_inc_n; it outputs a step strobe and a step sign.
- The top level holds the synchronisers, position registers, wrap/saturate logic and the write port.
- Existing seven-segment indicators stay external, driven from run and pen_mode.

## Test plan
All scenarios use GRID_W=80, GRID_H=60, INIT_DELAY=4, REPEAT_DELAY=2.
- Reset released, then right held for 10 cycles after sync -> cur_x steps 0->1 (t), 2 (t+4), 3 (t+6), 4 (t+8). No wr_en in hover.
- pen_mode=01, one short left+up tap at (5,5) -> (4,4) in one cycle, then a single wr_en with wr_x=4, wr_y=4, wr_color=1.
- wrap_en=0, cur_x=79, right pressed -> cur_x stays 79 and wr_en fires when pen_mode=10. wrap_en=1 -> cur_x becomes 0.
- Left and right both held -> no step, FSM stays IDLE. Releasing right -> first left step 2 edges later.
- run=0 with buttons held -> position frozen, no wr_en. run=1 -> immediate first step.
- clear during REPEAT at (30,20) -> (0,0) next edge, wr_en stays 0. Async rst_n mid-hold -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/grid_cursor_pkg.sv
// Shared types and helpers for the grid cursor controller: pen encodings,
// auto-repeat FSM states, direction type and the wrap/saturate step rule.
package grid_cursor_pkg;

  localparam logic [1:0] PEN_HOVER = 2'b00;
  localparam logic [1:0] PEN_DRAW  = 2'b01;
  localparam logic [1:0] PEN_ERASE = 2'b10;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_e;

  function automatic logic pen_writes(input logic [1:0] mode);
    return (mode == PEN_DRAW) || (mode == PEN_ERASE);
  endfunction

  // One cell move on an axis of `limit` cells, wrapping or saturating at the edges.
  function automatic int unsigned step_coord(input int unsigned pos, input logic dec,
                                             input logic wrap, input int unsigned limit);
    if (dec) begin
      if (pos == 32'd0) return wrap ? (limit - 32'd1) : 32'd0;
      return pos - 32'd1;
    end
    if (pos >= limit - 32'd1) return wrap ? 32'd0 : (limit - 32'd1);
    return pos + 32'd1;
  endfunction

endpackage

// File: rtl/grid_cursor_if.sv
// Cursor position and framebuffer write port of the grid cursor controller.
interface grid_cursor_if #(
  parameter int unsigned X_W = 7,
  parameter int unsigned Y_W = 6
);
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic           wr_en;
  logic [X_W-1:0] wr_x;
  logic [Y_W-1:0] wr_y;
  logic           wr_color;

  modport master (output cur_x, cur_y, wr_en, wr_x, wr_y, wr_color);
  modport slave  (input  cur_x, cur_y, wr_en, wr_x, wr_y, wr_color);
endinterface

// File: rtl/grid_cursor_axis_repeat.sv
// Per-axis auto-repeat: first step on press, one after INIT_DELAY clocks,
// then one every REPEAT_DELAY clocks while the same direction is held.
module axis_repeat
  import grid_cursor_pkg::*;
#(
  parameter int unsigned LIMIT        = 80,
  parameter int unsigned INIT_DELAY   = 5_000_000,
  parameter int unsigned REPEAT_DELAY = 1_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic pos_dec_n,
  input  logic pos_inc_n,
  output logic step_c,
  output logic step_dec_c
);

  localparam int unsigned MAX_DELAY = (INIT_DELAY > REPEAT_DELAY) ? INIT_DELAY : REPEAT_DELAY;
  localparam int unsigned T_W       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  if (LIMIT < 2 || INIT_DELAY < 1 || REPEAT_DELAY < 1) begin : g_bad_params
    $error("axis_repeat: LIMIT must be >= 2 and both delays >= 1");
  end

  rpt_state_e     state_q, state_d;
  logic [T_W-1:0] timer_q, timer_d;
  dir_e           dir_q, dir_d;
  dir_e           dir_in;

  // Opposing buttons pressed together cancel out.
  always_comb begin : dir_decode
    dir_in = DIR_NONE;
    if (!pos_inc_n && pos_dec_n)      dir_in = DIR_INC;
    else if (!pos_dec_n && pos_inc_n) dir_in = DIR_DEC;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= RPT_IDLE;
      timer_q <= '0;
      dir_q   <= DIR_NONE;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end

  // A changed direction while holding drops to IDLE, so the new press restarts next cycle.
  always_comb begin : next_state
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    if (!en_i || dir_in == DIR_NONE) begin
      state_d = RPT_IDLE;
      timer_d = '0;
      dir_d   = DIR_NONE;
    end else begin
      unique case (state_q)
        RPT_IDLE: begin
          state_d = RPT_HOLD;
          timer_d = T_W'(INIT_DELAY - 1);
          dir_d   = dir_in;
        end
        RPT_HOLD, RPT_REPEAT: begin
          if (dir_in != dir_q) begin
            state_d = RPT_IDLE;
            timer_d = '0;
            dir_d   = DIR_NONE;
          end else if (timer_q == '0) begin
            state_d = RPT_REPEAT;
            timer_d = T_W'(REPEAT_DELAY - 1);
          end else begin
            timer_d = timer_q - T_W'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          timer_d = '0;
          dir_d   = DIR_NONE;
        end
      endcase
    end
  end

  always_comb begin : outputs
    step_c     = 1'b0;
    step_dec_c = (dir_in == DIR_DEC);
    if (en_i && dir_in != DIR_NONE) begin
      unique case (state_q)
        RPT_IDLE:             step_c = 1'b1;
        RPT_HOLD, RPT_REPEAT: step_c = (dir_in == dir_q) && (timer_q == '0);
        default:              step_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/grid_cursor.sv
// Whiteboard cursor controller: synchronises the buttons, moves the cursor
// over the grid with per-axis auto-repeat and issues registered pen writes.
module grid_cursor
  import grid_cursor_pkg::*;
#(
  parameter int unsigned GRID_W       = 80,
  parameter int unsigned GRID_H       = 60,
  parameter int unsigned INIT_DELAY   = 5_000_000,
  parameter int unsigned REPEAT_DELAY = 1_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       run,
  input  logic [1:0] pen_mode,
  input  logic       wrap_en,
  input  logic       clear,
  grid_cursor_if.master fb
);

  localparam int unsigned X_W = $clog2(GRID_W);
  localparam int unsigned Y_W = $clog2(GRID_H);

  logic [3:0]     sync1_q, sync2_q;  // {up, down, left, right}, active-low
  logic [X_W-1:0] cur_x_q, cur_x_d, wr_x_q;
  logic [Y_W-1:0] cur_y_q, cur_y_d, wr_y_q;
  logic [1:0]     pen_q;
  logic           pend_q, pend_d;
  logic           wr_en_q, wr_en_d;
  logic           wr_color_q;
  logic           axis_en;
  logic           step_x, dec_x, step_y, dec_y;

  assign axis_en = run & ~clear;

  axis_repeat #(
    .LIMIT       (GRID_W),
    .INIT_DELAY  (INIT_DELAY),
    .REPEAT_DELAY(REPEAT_DELAY)
  ) u_axis_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (axis_en),
    .pos_dec_n (sync2_q[1]),
    .pos_inc_n (sync2_q[0]),
    .step_c    (step_x),
    .step_dec_c(dec_x)
  );

  axis_repeat #(
    .LIMIT       (GRID_H),
    .INIT_DELAY  (INIT_DELAY),
    .REPEAT_DELAY(REPEAT_DELAY)
  ) u_axis_y (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (axis_en),
    .pos_dec_n (sync2_q[3]),
    .pos_inc_n (sync2_q[2]),
    .step_c    (step_y),
    .step_dec_c(dec_y)
  );

  always_comb begin : pos_next
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (clear) begin
      cur_x_d = '0;
      cur_y_d = '0;
    end else begin
      if (step_x) cur_x_d = X_W'(step_coord(32'(cur_x_q), dec_x, wrap_en, GRID_W));
      if (step_y) cur_y_d = Y_W'(step_coord(32'(cur_y_q), dec_y, wrap_en, GRID_H));
    end
  end

  // A request lands one cycle after the step, so the write carries the moved position.
  always_comb begin : write_next
    pend_d  = axis_en & (step_x | step_y | (~pen_writes(pen_q) & pen_writes(pen_mode)));
    wr_en_d = pend_q & axis_en & pen_writes(pen_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      pen_q      <= PEN_HOVER;
      pend_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= 1'b0;
    end else begin
      sync1_q <= {btn_up_n, btn_down_n, btn_left_n, btn_right_n};
      sync2_q <= sync1_q;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      pen_q   <= pen_mode;
      pend_q  <= pend_d;
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_x_q     <= cur_x_q;
        wr_y_q     <= cur_y_q;
        wr_color_q <= pen_mode[0];
      end
    end
  end

  assign fb.cur_x    = cur_x_q;
  assign fb.cur_y    = cur_y_q;
  assign fb.wr_en    = wr_en_q;
  assign fb.wr_x     = wr_x_q;
  assign fb.wr_y     = wr_y_q;
  assign fb.wr_color = wr_color_q;

endmodule

// File: tb/tb_grid_cursor.sv
// Randomised scoreboard bench for grid_cursor against a hold-count reference model.
module tb_grid_cursor;
  import grid_cursor_pkg::*;

  localparam int unsigned GW = 80;
  localparam int unsigned GH = 60;
  localparam int unsigned ID = 4;
  localparam int unsigned RD = 2;
  localparam int unsigned XW = $clog2(GW);
  localparam int unsigned YW = $clog2(GH);

  localparam logic [3:0] B_RIGHT = 4'b0001;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_UP    = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] press = 4'b0;  // active-high {up, down, left, right}
  logic       run = 1'b0;
  logic [1:0] pen_mode = PEN_HOVER;
  logic       wrap_en = 1'b0;
  logic       clear = 1'b0;

  int total = 0;
  int bad   = 0;

  grid_cursor_if #(.X_W(XW), .Y_W(YW)) fb ();

  grid_cursor #(
    .GRID_W      (GW),
    .GRID_H      (GH),
    .INIT_DELAY  (ID),
    .REPEAT_DELAY(RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_n   (~press[3]),
    .btn_down_n (~press[2]),
    .btn_left_n (~press[1]),
    .btn_right_n(~press[0]),
    .run        (run),
    .pen_mode   (pen_mode),
    .wrap_en    (wrap_en),
    .clear      (clear),
    .fb         (fb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x;
    int   y;
    logic c;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state: pin history, per-axis hold counters, position.
  int         m_x = 0;
  int         m_y = 0;
  logic       m_pend = 1'b0;
  logic [1:0] m_pen_prev = PEN_HOVER;
  logic [3:0] m_s1 = 4'b0;
  logic [3:0] m_s2 = 4'b0;
  bit         ax_on[2];
  int         ax_cnt[2];
  int         ax_dir[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int net_dir(input logic inc, input logic dec);
    if (inc && !dec) return 1;
    if (dec && !inc) return -1;
    return 0;
  endfunction

  function automatic int move(input int pos, input int d, input int lim, input logic wrap);
    int p;
    p = pos + d;
    if (wrap) return (p + lim) % lim;
    if (p < 0) return 0;
    if (p > lim - 1) return lim - 1;
    return p;
  endfunction

  // Steps at hold counts 0, ID, ID+RD, ID+2*RD, ...
  function automatic bit step_at(input int n);
    return (n == 0) || (n == int'(ID)) || (n > int'(ID) && ((n - int'(ID)) % int'(RD)) == 0);
  endfunction

  always @(posedge clk) begin : model
    bit  live;
    int  d[2];
    bit  st[2];
    wr_t w;
    if (!rst_n) begin
      m_x = 0; m_y = 0; m_pend = 1'b0; m_pen_prev = PEN_HOVER;
      m_s1 = 4'b0; m_s2 = 4'b0;
      ax_on[0] = 1'b0; ax_on[1] = 1'b0;
      exp_q.delete();
    end else begin
      live = run && !clear;
      if (m_pend && live && pen_writes(pen_mode)) begin
        w.x = m_x; w.y = m_y; w.c = pen_mode[0];
        exp_q.push_back(w);
      end
      d[0] = net_dir(m_s2[0], m_s2[1]);
      d[1] = net_dir(m_s2[2], m_s2[3]);
      for (int a = 0; a < 2; a++) begin
        st[a] = 1'b0;
        if (!live || d[a] == 0) ax_on[a] = 1'b0;
        else if (ax_on[a] && d[a] != ax_dir[a]) ax_on[a] = 1'b0;
        else if (!ax_on[a]) begin
          ax_on[a] = 1'b1; ax_cnt[a] = 0; ax_dir[a] = d[a]; st[a] = 1'b1;
        end else begin
          ax_cnt[a]++;
          st[a] = step_at(ax_cnt[a]);
        end
      end
      if (clear) begin
        m_x = 0; m_y = 0;
      end else begin
        if (st[0]) m_x = move(m_x, d[0], int'(GW), wrap_en);
        if (st[1]) m_y = move(m_y, d[1], int'(GH), wrap_en);
      end
      m_pend = live && (st[0] || st[1] || (!pen_writes(m_pen_prev) && pen_writes(pen_mode)));
      m_pen_prev = pen_mode;
      m_s2 = m_s1;
      m_s1 = press;
    end
  end

  always @(negedge clk) begin : monitor
    wr_t w;
    if (rst_n) begin
      chk("cur_x", int'(fb.cur_x), m_x);
      chk("cur_y", int'(fb.cur_y), m_y);
      if (fb.wr_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write got x=%0d y=%0d c=%0d want none at %0t",
                   fb.wr_x, fb.wr_y, fb.wr_color, $time);
        end else begin
          w = exp_q.pop_front();
          chk("wr_x", int'(fb.wr_x), w.x);
          chk("wr_y", int'(fb.wr_y), w.y);
          chk("wr_color", int'(fb.wr_color), int'(w.c));
        end
      end else if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        total++; bad++;
        $display("FAIL missing_write got none want x=%0d y=%0d c=%0d at %0t", w.x, w.y, w.c, $time);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    press = p;
    cyc(n);
    press = 4'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cur_x"}, int'(fb.cur_x), 0);
    chk({tag, "_cur_y"}, int'(fb.cur_y), 0);
    chk({tag, "_wr_en"}, int'(fb.wr_en), 0);
    chk({tag, "_wr_x"}, int'(fb.wr_x), 0);
    chk({tag, "_wr_y"}, int'(fb.wr_y), 0);
    chk({tag, "_wr_color"}, int'(fb.wr_color), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stalled");
  end

  initial begin : stim
    cyc(3);
    chk_all_zero("reset");
    run = 1'b1;
    rst_n = 1'b1;
    cyc(2);

    // Hover hold: first step, then INIT then REPEAT cadence, no writes.
    hold(B_RIGHT, 12);
    cyc(4);

    // Draw: arrive at (5,5), enable draw (one write), then a diagonal tap.
    do_clear();
    hold(B_RIGHT | B_DOWN, 11);
    cyc(4);
    chk("at_5_5_x", int'(fb.cur_x), 5);
    chk("at_5_5_y", int'(fb.cur_y), 5);
    pen_mode = PEN_DRAW;
    cyc(4);
    hold(B_LEFT | B_UP, 1);
    cyc(5);
    chk("tap_x", int'(fb.cur_x), 4);
    chk("tap_y", int'(fb.cur_y), 4);

    // Edge behaviour: wrap to 79, saturate there with erase, then wrap to 0.
    pen_mode = PEN_HOVER;
    do_clear();
    wrap_en = 1'b1;
    hold(B_LEFT, 1);
    cyc(4);
    chk("wrap_left_x", int'(fb.cur_x), 79);
    wrap_en = 1'b0;
    pen_mode = PEN_ERASE;
    cyc(4);
    hold(B_RIGHT, 1);
    cyc(5);
    chk("sat_right_x", int'(fb.cur_x), 79);
    wrap_en = 1'b1;
    hold(B_RIGHT, 1);
    cyc(5);
    chk("wrap_right_x", int'(fb.cur_x), 0);

    // Opposing buttons cancel; releasing one starts the other.
    press = B_LEFT | B_RIGHT;
    cyc(8);
    press = B_LEFT;
    cyc(6);
    press = 4'b0;
    cyc(4);

    // Paused with buttons held, then resume.
    run = 1'b0;
    press = B_RIGHT | B_DOWN;
    cyc(8);
    run = 1'b1;
    cyc(7);
    press = B_LEFT;
    cyc(3);
    press = B_RIGHT;  // direct reversal
    cyc(6);
    press = 4'b0;
    cyc(4);

    // Clear while repeating with the button still held.
    press = B_RIGHT | B_DOWN;
    cyc(12);
    do_clear();
    cyc(6);
    press = 4'b0;
    cyc(4);

    // Asynchronous reset mid-hold, released with the button still down.
    press = B_DOWN | B_RIGHT;
    cyc(11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    press = 4'b0;
    cyc(4);

    // Randomised segments.
    for (int i = 0; i < 200; i++) begin
      press    = 4'($urandom_range(0, 15));
      run      = ($urandom_range(0, 9) != 0);
      pen_mode = 2'($urandom_range(0, 3));
      wrap_en  = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 19) == 0);
      cyc($urandom_range(1, 12));
      clear = 1'b0;
    end

    press = 4'b0;
    run   = 1'b1;
    cyc(6);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
